// File: rtl/spatz_vrf_warb.sv
// ----------------------------------------------------------------------------
// spatz_vrf_warb
//
// Write arbiter for a single VRF write port shared by NrRequesters units.
// A round-robin pointer selects one requester per cycle. The winner's payload
// is captured into a one-entry output slot that drives the VRF port. The slot
// can be drained and refilled in the same cycle, so a VRF that accepts every
// cycle sees back-to-back writes. A request reaches vrf_we_o one cycle after
// it is granted.
//
// Optional feature (macro SPATZ_VRF_WARB_PERF_EN):
//   defined   -> stall_cnt_o counts cycles with vrf_we_o=1 and
//                vrf_wvalid_i=0, saturating at all ones.
//   undefined -> stall_cnt_o is tied to zero and no counter is built.
//
// Ports:
//   clk_i         clock; all state changes on the rising edge
//   rst_ni        synchronous active-low reset
//   req_i         per-requester write request
//   waddr_i       per-requester write address
//   wdata_i       per-requester write data
//   wbe_i         per-requester byte enables
//   gnt_o         one-hot grant; the payload is captured in this cycle
//   vrf_we_o      VRF write enable (slot full)
//   vrf_waddr_o   registered write address
//   vrf_wdata_o   registered write data
//   vrf_wbe_o     registered byte enables
//   vrf_wvalid_i  VRF reports the write was performed this cycle
//   stall_cnt_o   stall cycle counter (see above)
//
// Slot states:
//   state | meaning
//   EMPTY | no pending write, vrf_we_o = 0
//   FULL  | payload registers hold a write, vrf_we_o = 1
// ----------------------------------------------------------------------------
module spatz_vrf_warb #(
    parameter int NrRequesters = 3,
    parameter int AddrWidth    = 5,
    parameter int DataWidth    = 256,
    parameter int BeWidth      = DataWidth / 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NrRequesters-1:0]                req_i,
    input  logic [NrRequesters-1:0][AddrWidth-1:0] waddr_i,
    input  logic [NrRequesters-1:0][DataWidth-1:0] wdata_i,
    input  logic [NrRequesters-1:0][BeWidth-1:0]   wbe_i,
    output logic [NrRequesters-1:0]                gnt_o,
    output logic                                   vrf_we_o,
    output logic [AddrWidth-1:0]                   vrf_waddr_o,
    output logic [DataWidth-1:0]                   vrf_wdata_o,
    output logic [BeWidth-1:0]                     vrf_wbe_o,
    input  logic                                   vrf_wvalid_i,
    output logic [31:0]                            stall_cnt_o
);

    localparam int RrWidth = (NrRequesters > 1) ? $clog2(NrRequesters) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [RrWidth-1:0]        rr_q, rr_d;

    logic [NrRequesters-1:0]   win_oh;
    logic [RrWidth-1:0]        win_next;
    logic                      win_found;
    int                        cand;
    logic                      slot_free;
    logic                      grant;

    logic [AddrWidth-1:0]      addr_sel, addr_q;
    logic [DataWidth-1:0]      data_sel, data_q;
    logic [BeWidth-1:0]        be_sel, be_q;

    // Round-robin search: offset i walks rr_q, rr_q+1, ... modulo
    // NrRequesters. Indices into req_i stay constant so the search unrolls
    // into a plain priority mux.
    always_comb begin
        win_oh    = '0;
        win_next  = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NrRequesters; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NrRequesters) begin
                cand = cand - NrRequesters;
            end
            for (int k = 0; k < NrRequesters; k++) begin
                if (!win_found && (k == cand) && req_i[k]) begin
                    win_found = 1'b1;
                    win_oh[k] = 1'b1;
                    win_next  = (k == NrRequesters - 1) ? '0 : RrWidth'(k + 1);
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        be_sel   = '0;
        for (int k = 0; k < NrRequesters; k++) begin
            if (win_oh[k]) begin
                addr_sel = waddr_i[k];
                data_sel = wdata_i[k];
                be_sel   = wbe_i[k];
            end
        end
    end

    // Next-state and grant logic. A full slot counts as free when the VRF
    // takes its write this cycle, which allows drain and refill together.
    // Grants are gated by reset so nothing is accepted while rst_ni is low.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        slot_free = (state_q == EMPTY) || vrf_wvalid_i;
        grant     = rst_ni && slot_free && win_found;
        gnt_o     = grant ? win_oh : '0;
        if (grant) begin
            state_d = FULL;
            rr_d    = win_next;
        end else if ((state_q == FULL) && vrf_wvalid_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Data path only loads on a grant; its contents are irrelevant while
    // the slot is empty, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            addr_q <= addr_sel;
            data_q <= data_sel;
            be_q   <= be_sel;
        end
    end

    assign vrf_we_o    = (state_q == FULL);
    assign vrf_waddr_o = addr_q;
    assign vrf_wdata_o = data_q;
    assign vrf_wbe_o   = be_q;

`ifdef SPATZ_VRF_WARB_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == FULL) && !vrf_wvalid_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_spatz_vrf_warb.sv
module tb_spatz_vrf_warb;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 256;
    localparam int BW = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [N-1:0]          req_i;
    logic [N-1:0][AW-1:0]  waddr_i;
    logic [N-1:0][DW-1:0]  wdata_i;
    logic [N-1:0][BW-1:0]  wbe_i;
    logic [N-1:0]          gnt_o;
    logic                  vrf_we_o;
    logic [AW-1:0]         vrf_waddr_o;
    logic [DW-1:0]         vrf_wdata_o;
    logic [BW-1:0]         vrf_wbe_o;
    logic                  vrf_wvalid_i;
    logic [31:0]           stall_cnt_o;

    spatz_vrf_warb #(
        .NrRequesters(N),
        .AddrWidth   (AW),
        .DataWidth   (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .wbe_i       (wbe_i),
        .gnt_o       (gnt_o),
        .vrf_we_o    (vrf_we_o),
        .vrf_waddr_o (vrf_waddr_o),
        .vrf_wdata_o (vrf_wdata_o),
        .vrf_wbe_o   (vrf_wbe_o),
        .vrf_wvalid_i(vrf_wvalid_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } wr_t;

    typedef struct {
        logic [N-1:0] req;
        logic         wv;
        logic [N-1:0] eg;
        logic         ew;
    } vec_t;

    wr_t         sb[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          seq[N];
    logic        ovr = 1'b0;
    logic [31:0] stall_exp = 32'd0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Each requester presents a payload derived from its index and how many
    // times it has been granted, so lost or duplicated writes show up.
    task automatic drive_payload();
        for (int k = 0; k < N; k++) begin
            waddr_i[k] = AW'(3 * k + 5 * seq[k] + 1);
            for (int j = 0; j < 8; j++) begin
                wdata_i[k][j*32 +: 32] = (32'(k) << 28) ^ (32'(seq[k]) * 32'h9E37_79B9) ^ 32'(j);
            end
            wbe_i[k] = ~(32'd1 << ((k * 5 + seq[k]) % 32));
            if (ovr && k == 1) begin
                waddr_i[k] = AW'(7);
                wbe_i[k]   = '1;
            end
        end
    endtask

    // Called just after a rising edge: drive inputs, compare in mid-cycle,
    // update scoreboard, advance to just after the next rising edge.
    task automatic apply(input logic [N-1:0] req, input logic wv,
                         input logic [N-1:0] eg, input logic ew, input string nm);
        wr_t e;
        req_i        = req;
        vrf_wvalid_i = wv;
        drive_payload();
        #3;
        check({nm, " gnt"},   256'(gnt_o),       256'(eg));
        check({nm, " we"},    256'(vrf_we_o),    256'(ew));
        check({nm, " stall"}, 256'(stall_cnt_o), 256'(stall_exp));
        if (ew && wv) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s sb: got write, expected none", nm);
            end else begin
                e = sb.pop_front();
                check({nm, " addr"}, 256'(vrf_waddr_o), 256'(e.addr));
                check({nm, " data"}, vrf_wdata_o,       e.data);
                check({nm, " be"},   256'(vrf_wbe_o),   256'(e.be));
            end
        end
`ifdef SPATZ_VRF_WARB_PERF_EN
        if (ew && !wv && stall_exp != 32'hFFFF_FFFF) stall_exp++;
`endif
        for (int k = 0; k < N; k++) begin
            if (eg[k]) begin
                sb.push_back('{waddr_i[k], wdata_i[k], wbe_i[k]});
                seq[k]++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) seq[k] = 0;
        rst_ni       = 1'b0;
        req_i        = '0;
        vrf_wvalid_i = 1'b0;
        drive_payload();
        repeat (2) @(posedge clk_i);
        #1;

        // Grants suppressed while reset is held, even with requests pending.
        apply(3'b111, 1'b1, 3'b000, 1'b0, "in_reset");
        rst_ni = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) apply(3'b000, 1'b0, 3'b000, 1'b0, $sformatf("idle%0d", i));

        // All requesting, VRF accepting each cycle; then wrap from rr=2.
        tbl.push_back('{3'b111, 1'b1, 3'b001, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b010, 1'b1});
        tbl.push_back('{3'b111, 1'b1, 3'b100, 1'b1});
        tbl.push_back('{3'b111, 1'b1, 3'b001, 1'b1});
        tbl.push_back('{3'b000, 1'b1, 3'b000, 1'b1});
        tbl.push_back('{3'b000, 1'b0, 3'b000, 1'b0});
        tbl.push_back('{3'b010, 1'b1, 3'b010, 1'b0});
        tbl.push_back('{3'b011, 1'b1, 3'b001, 1'b1});
        tbl.push_back('{3'b010, 1'b1, 3'b010, 1'b1});
        tbl.push_back('{3'b000, 1'b1, 3'b000, 1'b1});
        tbl.push_back('{3'b000, 1'b0, 3'b000, 1'b0});
        foreach (tbl[i]) apply(tbl[i].req, tbl[i].wv, tbl[i].eg, tbl[i].ew, $sformatf("vec%0d", i));

        // Stall: requester 1 writes addr 7, VRF holds off for 3 cycles while
        // requester 0 waits; payload must stay put and no grant issued.
        ovr = 1'b1;
        apply(3'b010, 1'b0, 3'b010, 1'b0, "stall_gnt");
        ovr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d addr7", i), 256'(vrf_waddr_o), 256'(7));
            check($sformatf("stall%0d be", i),    256'(vrf_wbe_o),   256'(32'hFFFF_FFFF));
            apply(3'b001, 1'b0, 3'b000, 1'b1, $sformatf("stall%0d", i));
        end
        check("stall_end addr7", 256'(vrf_waddr_o), 256'(7));
        apply(3'b001, 1'b1, 3'b001, 1'b1, "stall_end");
        apply(3'b000, 1'b1, 3'b000, 1'b1, "stall_drain");
        apply(3'b000, 1'b0, 3'b000, 1'b0, "stall_idle");

        // Reset while full drops the write and returns rr to 0.
        apply(3'b010, 1'b0, 3'b010, 1'b0, "pre_rst");
        rst_ni = 1'b0;
        apply(3'b000, 1'b0, 3'b000, 1'b1, "rst_full");
        rst_ni    = 1'b1;
        stall_exp = 32'd0;
        sb.delete();
        apply(3'b110, 1'b0, 3'b010, 1'b0, "post_rst");
        apply(3'b100, 1'b1, 3'b100, 1'b1, "post_rst2");
        apply(3'b000, 1'b1, 3'b000, 1'b1, "post_rst3");
        apply(3'b000, 1'b0, 3'b000, 1'b0, "post_rst4");

        // Single requester streaming with VRF accepting every other cycle.
        for (int i = 0; i < 16; i++) begin
            apply(3'b001, (i % 2 == 0) ? 1'b1 : 1'b0, (i % 2 == 0) ? 3'b001 : 3'b000,
                  (i == 0) ? 1'b0 : 1'b1, $sformatf("stream%0d", i));
        end
        apply(3'b000, 1'b0, 3'b000, 1'b1, "stream_tail0");
        apply(3'b000, 1'b1, 3'b000, 1'b1, "stream_tail1");
        apply(3'b000, 1'b0, 3'b000, 1'b0, "stream_idle");

        check("sb_empty", 256'(sb.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
